overlay_anim_ctrl: RTL and testbench

- Frame-rate sequencer for the sprite-collision and text-reveal overlay.
- Owns all animation state: sprite X positions, sprite visibility, collision decision and revealed-letter count.
- Advances on vsync rising edges and drives the pixel-compositing datapath, which keeps only the raster counters and ROM lookups.
- Adds start/abort/pause control, a post-reveal hold, optional looping and a done pulse.

---
 rtl/overlay_pkg.sv | 49 ++++
 rtl/frame_tick_gen.sv | 37 +++
 rtl/overlay_anim_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_overlay_anim_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : overlay_pkg
//  Purpose  : Shared types, geometry constants and the collision predicate
//             for the sprite-collision / text-reveal overlay. Imported by the
//             frame-rate sequencer and by the pixel-compositing datapath.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package overlay_pkg;

  // Video / sprite geometry
  localparam int H_ACTIVE     = 1920;
  localparam int V_ACTIVE     = 1080;
  localparam int SPR_W_SCALED = 256;
  localparam int MARGIN       = 20;

  // Message length in letters
  localparam int TEXT_LEN     = 11;

  // Sequencer state encodings (3-bit, kept stable for debug tooling)
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_APPROACH = 3'd1;
  localparam logic [2:0] ST_REVEAL   = 3'd2;
  localparam logic [2:0] ST_HOLD     = 3'd3;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    APPROACH = ST_APPROACH,
    REVEAL   = ST_REVEAL,
    HOLD     = ST_HOLD
  } state_e;

  // Two sprites collide once their margin-inset spans overlap. All operands
  // are 12-bit unsigned; the widest sum (1919 + 256) still fits, so nothing
  // wraps.
  function automatic logic collide(input logic [11:0] xa,
                                   input logic [11:0] xb,
                                   input logic [11:0] spr_w,
                                   input logic [11:0] margin);
    logic a_right_past_b_left;
    logic a_left_before_b_right;
    a_right_past_b_left   = ((xa + spr_w - margin) >= (xb + margin));
    a_left_before_b_right = ((xa + margin) <= (xb + spr_w - margin));
    return a_right_past_b_left && a_left_before_b_right;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : frame_tick_gen
//  Purpose  : Rising-edge detector on vertical sync, qualified by a clock
//             enable. Produces exactly one single-cycle tick per vsync rise
//             as seen on enabled cycles.
//  Ports    : clk_i    - pixel clock
//             rst_ni   - asynchronous reset, active low
//             cen_i    - clock enable; the sync history only advances on it
//             vsync_i  - vertical sync input
//             tick_o   - frame tick (combinational, valid while cen_i=1)
//  Revision : 1.0 - initial release
// ============================================================================
module frame_tick_gen (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cen_i,
  input  logic vsync_i,
  output logic tick_o
);

  logic vsync_q;

  // History only moves on enabled cycles, so a rise that happens entirely
  // while cen_i is low (and falls again) never produces a tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q <= 1'b0;
    end else if (cen_i) begin
      vsync_q <= vsync_i;
    end
  end

  assign tick_o = cen_i & vsync_i & ~vsync_q;

endmodule
`default_nettype wire

// File: rtl/overlay_anim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : overlay_anim_ctrl
//  Purpose  : Frame-rate sequencer for the sprite-collision and text-reveal
//             overlay. Moves two sprites toward each other, hides them on
//             collision, reveals the message one letter at a time, holds the
//             full text and then either loops or returns to idle.
//  Ports    : clk_i         - pixel clock
//             rst_ni        - asynchronous reset, active low
//             cen_i         - clock enable gating every state update
//             vsync_i       - vertical sync
//             start_i       - begin a sequence (honoured in IDLE only)
//             abort_i       - return to IDLE with cleared outputs
//             pause_i       - ignore frame ticks while high
//             x_a_o/x_b_o   - left/right sprite X position
//             sprites_vis_o - sprites drawn
//             letters_o     - letters revealed, 0..TEXT_LEN
//             busy_o        - sequencer not idle
//             done_o        - one-cen-cycle pulse at end of hold
//             state_o       - registered state encoding (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module overlay_anim_ctrl #(
  parameter int H_ACTIVE          = overlay_pkg::H_ACTIVE,
  parameter int SPR_W_SCALED      = overlay_pkg::SPR_W_SCALED,
  parameter int STEP              = 3,
  parameter int MARGIN            = overlay_pkg::MARGIN,
  parameter int TEXT_LEN          = overlay_pkg::TEXT_LEN,
  parameter int FRAMES_PER_LETTER = 6,
  parameter int HOLD_FRAMES       = 120,
  parameter int LOOP              = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cen_i,
  input  logic        vsync_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        pause_i,
  output logic [10:0] x_a_o,
  output logic [10:0] x_b_o,
  output logic        sprites_vis_o,
  output logic [3:0]  letters_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  state_o
);

  import overlay_pkg::*;

  // Home position of the right sprite: flush against the right edge.
  localparam int X_B_HOME = H_ACTIVE - SPR_W_SCALED;
  // Left sprite keeps moving while its right edge is short of this line.
  localparam int A_LIMIT  = H_ACTIVE / 2 + SPR_W_SCALED / 2;
  // Right sprite keeps moving while its left edge is beyond this line.
  localparam int B_LIMIT  = H_ACTIVE / 2 - SPR_W_SCALED / 2;

  // One counter serves both the per-letter pacing and the hold period.
  localparam int CNT_MAX  = (HOLD_FRAMES > FRAMES_PER_LETTER) ? HOLD_FRAMES
                                                              : FRAMES_PER_LETTER;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  // --------------------------------------------------------------------------
  // Frame tick
  // --------------------------------------------------------------------------
  logic tick;

  frame_tick_gen u_tick (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .cen_i   (cen_i),
    .vsync_i (vsync_i),
    .tick_o  (tick)
  );

  // A paused tick is still consumed by the edge detector, it just has no
  // effect on the animation.
  logic tick_go;
  assign tick_go = tick & ~pause_i;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e            state_q,   state_d;
  logic [10:0]       x_a_q,     x_a_d;
  logic [10:0]       x_b_q,     x_b_d;
  logic              vis_q,     vis_d;
  logic [3:0]        letters_q, letters_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  // Geometry is evaluated at 12 bits on the registered positions.
  logic [11:0] x_a_ext;
  logic [11:0] x_b_ext;
  logic        collide_w;
  logic        a_may_move;
  logic        b_may_move;

  assign x_a_ext    = {1'b0, x_a_q};
  assign x_b_ext    = {1'b0, x_b_q};
  assign collide_w  = collide(x_a_ext, x_b_ext, 12'(SPR_W_SCALED), 12'(MARGIN));
  assign a_may_move = (x_a_ext + 12'(SPR_W_SCALED)) < 12'(A_LIMIT);
  assign b_may_move = x_b_ext > 12'(B_LIMIT);

  always_comb begin
    state_d   = state_q;
    x_a_d     = x_a_q;
    x_b_d     = x_b_q;
    vis_d     = vis_q;
    letters_d = letters_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;

    if (abort_i) begin
      state_d   = IDLE;
      x_a_d     = '0;
      x_b_d     = 11'(X_B_HOME);
      vis_d     = 1'b0;
      letters_d = '0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d   = APPROACH;
            x_a_d     = '0;
            x_b_d     = 11'(X_B_HOME);
            vis_d     = 1'b1;
            letters_d = '0;
            cnt_d     = '0;
          end
        end

        APPROACH: begin
          if (tick_go) begin
            if (collide_w) begin
              // Positions freeze where the sprites met.
              state_d = REVEAL;
              vis_d   = 1'b0;
              cnt_d   = '0;
            end else begin
              if (a_may_move) x_a_d = x_a_q + 11'(STEP);
              if (b_may_move) x_b_d = x_b_q - 11'(STEP);
            end
          end
        end

        REVEAL: begin
          if (tick_go) begin
            if (letters_q >= 4'(TEXT_LEN)) begin
              // Unreachable in normal flow; keeps the count from overrunning.
              state_d = HOLD;
              cnt_d   = '0;
            end else if (cnt_q == CNT_W'(FRAMES_PER_LETTER - 1)) begin
              cnt_d     = '0;
              letters_d = letters_q + 4'd1;
              if ((letters_q + 4'd1) == 4'(TEXT_LEN)) begin
                state_d = HOLD;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        HOLD: begin
          if (tick_go) begin
            if (cnt_q == CNT_W'(HOLD_FRAMES - 1)) begin
              done_d = 1'b1;
              cnt_d  = '0;
              if (LOOP != 0) begin
                state_d   = APPROACH;
                x_a_d     = '0;
                x_b_d     = 11'(X_B_HOME);
                vis_d     = 1'b1;
                letters_d = '0;
              end else begin
                // Letters and positions stay on screen until the next start.
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      x_a_q     <= '0;
      x_b_q     <= 11'(X_B_HOME);
      vis_q     <= 1'b0;
      letters_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (cen_i) begin
      state_q   <= state_d;
      x_a_q     <= x_a_d;
      x_b_q     <= x_b_d;
      vis_q     <= vis_d;
      letters_q <= letters_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x_a_o         = x_a_q;
  assign x_b_o         = x_b_q;
  assign sprites_vis_o = vis_q;
  assign letters_o     = letters_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_overlay_anim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_overlay_anim_ctrl
//  Purpose  : Self-checking bench for overlay_anim_ctrl. Two instances share
//             one stimulus stream: one returns to idle after the hold, the
//             other loops. A reference model predicts both every cycle; a
//             monitor pops and compares the predictions.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_overlay_anim_ctrl;

  localparam int H     = 1920;
  localparam int S     = 256;
  localparam int STEP  = 3;
  localparam int MRG   = 20;
  localparam int TL    = 11;
  localparam int FPL   = 6;
  localparam int HOLDF = 120;
  localparam int HOME  = H - S;
  localparam int LIM_A = H / 2 + S / 2 - S;           // left X limit
  localparam int LIM_B = H / 2 - S / 2;               // right X limit
  localparam int KA    = (LIM_A + STEP - 1) / STEP;   // moves available to A
  localparam int KB    = (HOME - LIM_B + STEP - 1) / STEP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ni, cen, vsync, start, abort, pause;

  logic [10:0] xa_o [2];
  logic [10:0] xb_o [2];
  logic        vis_o [2];
  logic [3:0]  let_o [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic [2:0]  st_o [2];

  overlay_anim_ctrl #(.LOOP(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .cen_i(cen), .vsync_i(vsync),
    .start_i(start), .abort_i(abort), .pause_i(pause),
    .x_a_o(xa_o[0]), .x_b_o(xb_o[0]), .sprites_vis_o(vis_o[0]),
    .letters_o(let_o[0]), .busy_o(busy_o[0]), .done_o(done_o[0]),
    .state_o(st_o[0])
  );

  overlay_anim_ctrl #(.LOOP(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .cen_i(cen), .vsync_i(vsync),
    .start_i(start), .abort_i(abort), .pause_i(pause),
    .x_a_o(xa_o[1]), .x_b_o(xb_o[1]), .sprites_vis_o(vis_o[1]),
    .letters_o(let_o[1]), .busy_o(busy_o[1]), .done_o(done_o[1]),
    .state_o(st_o[1])
  );

  typedef struct packed {
    logic [10:0] xa;
    logic [10:0] xb;
    logic        vis;
    logic [3:0]  lett;
    logic        busy;
    logic        done;
    logic [2:0]  st;
  } snap_t;

  typedef struct packed {
    snap_t s1;
    snap_t s0;
  } pair_t;

  pair_t sb_q[$];

  int n_total = 0;
  int n_bad   = 0;

  // --------------------------------------------------------------------------
  // Reference model: progress is tracked as counts of accepted ticks in each
  // phase; outputs are derived from those counts arithmetically.
  // --------------------------------------------------------------------------
  int m_st   [2];   // 0 idle, 1 approach, 2 reveal, 3 hold
  int m_app  [2];   // ticks taken while approaching
  int m_rev  [2];   // ticks taken while revealing
  int m_hold [2];   // ticks taken while holding
  int m_vis  [2];
  int m_done [2];
  int m_prev;       // last vsync seen on an enabled cycle

  function automatic int pos_a(int n);
    return STEP * ((n < KA) ? n : KA);
  endfunction

  function automatic int pos_b(int n);
    return HOME - STEP * ((n < KB) ? n : KB);
  endfunction

  function automatic bit model_collide(int xa, int xb);
    return (xa + S - MRG >= xb + MRG) && (xa + MRG <= xb + S - MRG);
  endfunction

  task automatic model_start(int i);
    m_st[i]   = 1;
    m_app[i]  = 0;
    m_rev[i]  = 0;
    m_hold[i] = 0;
    m_vis[i]  = 1;
  endtask

  task automatic model_step();
    bit tk;
    if (!rst_ni) begin
      m_prev = 0;
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_app[i] = 0; m_rev[i] = 0; m_hold[i] = 0;
        m_vis[i] = 0; m_done[i] = 0;
      end
    end else if (cen) begin
      tk     = (vsync == 1'b1) && (m_prev == 0);
      m_prev = (vsync == 1'b1) ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
        m_done[i] = 0;
        if (abort) begin
          m_st[i] = 0; m_app[i] = 0; m_rev[i] = 0; m_hold[i] = 0; m_vis[i] = 0;
        end else if (m_st[i] == 0) begin
          if (start) model_start(i);
        end else if (tk && !pause) begin
          case (m_st[i])
            1: begin
              if (model_collide(pos_a(m_app[i]), pos_b(m_app[i]))) begin
                m_st[i]  = 2;
                m_vis[i] = 0;
                m_rev[i] = 0;
              end else begin
                m_app[i]++;
              end
            end
            2: begin
              m_rev[i]++;
              if (m_rev[i] == TL * FPL) begin
                m_st[i]   = 3;
                m_hold[i] = 0;
              end
            end
            default: begin
              m_hold[i]++;
              if (m_hold[i] == HOLDF) begin
                m_done[i] = 1;
                if (i == 1) model_start(i);
                else        m_st[i] = 0;
              end
            end
          endcase
        end
      end
    end
  endtask

  function automatic snap_t exp_snap(int i);
    snap_t s;
    int    l;
    l      = m_rev[i] / FPL;
    s.xa   = 11'(pos_a(m_app[i]));
    s.xb   = 11'(pos_b(m_app[i]));
    s.vis  = (m_vis[i] != 0);
    s.lett = 4'((l > TL) ? TL : l);
    s.busy = (m_st[i] != 0);
    s.done = (m_done[i] != 0);
    s.st   = 3'(m_st[i]);
    return s;
  endfunction

  function automatic snap_t dut_snap(int i);
    snap_t s;
    s.xa = xa_o[i]; s.xb = xb_o[i]; s.vis = vis_o[i]; s.lett = let_o[i];
    s.busy = busy_o[i]; s.done = done_o[i]; s.st = st_o[i];
    return s;
  endfunction

  // Apply current inputs for one clock: predict, enqueue, advance.
  task automatic step();
    pair_t p;
    model_step();
    p.s0 = exp_snap(0);
    p.s1 = exp_snap(1);
    sb_q.push_back(p);
    @(posedge clk);
    #2;
  endtask

  task automatic tick(int n);
    for (int k = 0; k < n; k++) begin
      vsync = 1'b0; step();
      vsync = 1'b1; step();
    end
  endtask

  task automatic chk(string name, int i, int got, int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] got=%0d expected=%0d at %0t", name, i, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_state"}, i, int'(st_o[i]), 0);
      chk({tag, "_xa"},    i, int'(xa_o[i]), 0);
      chk({tag, "_xb"},    i, int'(xb_o[i]), 1664);
      chk({tag, "_vis"},   i, int'(vis_o[i]), 0);
      chk({tag, "_let"},   i, int'(let_o[i]), 0);
      chk({tag, "_busy"},  i, int'(busy_o[i]), 0);
      chk({tag, "_done"},  i, int'(done_o[i]), 0);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: one prediction per clock, compared just after the edge.
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        pair_t e;
        snap_t a, x;
        e = sb_q.pop_front();
        for (int i = 0; i < 2; i++) begin
          a = dut_snap(i);
          x = (i == 0) ? e.s0 : e.s1;
          n_total++;
          if (a !== x) begin
            n_bad++;
            $display("FAIL sb[dut%0d] t=%0t got xa=%0d xb=%0d vis=%0d let=%0d busy=%0d done=%0d st=%0d expected xa=%0d xb=%0d vis=%0d let=%0d busy=%0d done=%0d st=%0d",
                     i, $time, a.xa, a.xb, a.vis, a.lett, a.busy, a.done, a.st,
                     x.xa, x.xb, x.vis, x.lett, x.busy, x.done, x.st);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst_ni = 1'b0; cen = 1'b1; vsync = 1'b0;
    start  = 1'b0; abort = 1'b0; pause = 1'b0;
    model_step();
    repeat (2) @(posedge clk);
    #2;
    chk_reset_vals("reset");
    rst_ni = 1'b1;

    // Approach up to and through the collision.
    start = 1'b1; step(); start = 1'b0;
    tick(241);
    for (int i = 0; i < 2; i++) begin
      chk("t241_xa", i, int'(xa_o[i]), 723);
      chk("t241_xb", i, int'(xb_o[i]), 941);
      chk("t241_vis", i, int'(vis_o[i]), 1);
    end
    tick(1);
    for (int i = 0; i < 2; i++) begin
      chk("t242_xa", i, int'(xa_o[i]), 726);
      chk("t242_xb", i, int'(xb_o[i]), 938);
    end
    tick(1);
    for (int i = 0; i < 2; i++) begin
      chk("t243_state", i, int'(st_o[i]), 2);
      chk("t243_vis", i, int'(vis_o[i]), 0);
      chk("t243_xa", i, int'(xa_o[i]), 726);
      chk("t243_xb", i, int'(xb_o[i]), 938);
    end

    // Reveal with a pause, an ignored start and a cen-masked vsync rise.
    tick(20);
    for (int i = 0; i < 2; i++) chk("rev20_let", i, int'(let_o[i]), 3);
    pause = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    tick(10);
    pause = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("pause_let", i, int'(let_o[i]), 3);
      chk("pause_state", i, int'(st_o[i]), 2);
    end
    vsync = 1'b0; step();
    cen = 1'b0; vsync = 1'b1; step(); step();
    vsync = 1'b0; step();
    cen = 1'b1; step();
    tick(45);
    for (int i = 0; i < 2; i++) begin
      chk("rev65_let", i, int'(let_o[i]), 10);
      chk("rev65_state", i, int'(st_o[i]), 2);
    end
    tick(1);
    for (int i = 0; i < 2; i++) begin
      chk("rev66_let", i, int'(let_o[i]), 11);
      chk("rev66_state", i, int'(st_o[i]), 3);
    end

    // Hold and exit.
    tick(119);
    for (int i = 0; i < 2; i++) begin
      chk("hold119_done", i, int'(done_o[i]), 0);
      chk("hold119_state", i, int'(st_o[i]), 3);
    end
    tick(1);
    chk("exit_done", 0, int'(done_o[0]), 1);
    chk("exit_state", 0, int'(st_o[0]), 0);
    chk("exit_busy", 0, int'(busy_o[0]), 0);
    chk("exit_let", 0, int'(let_o[0]), 11);
    chk("exit_xa", 0, int'(xa_o[0]), 726);
    chk("loop_done", 1, int'(done_o[1]), 1);
    chk("loop_state", 1, int'(st_o[1]), 1);
    chk("loop_xa", 1, int'(xa_o[1]), 0);
    chk("loop_xb", 1, int'(xb_o[1]), 1664);
    chk("loop_let", 1, int'(let_o[1]), 0);
    chk("loop_vis", 1, int'(vis_o[1]), 1);
    step();
    for (int i = 0; i < 2; i++) chk("done_pulse_end", i, int'(done_o[i]), 0);

    // Abort together with start mid-approach.
    start = 1'b1; step(); start = 1'b0;
    tick(100);
    for (int i = 0; i < 2; i++) chk("app100_xa", i, int'(xa_o[i]), 300);
    abort = 1'b1; start = 1'b1; step();
    abort = 1'b0; start = 1'b0;
    chk_reset_vals("abort");

    // Asynchronous reset in the middle of the hold, vsync left high.
    start = 1'b1; step(); start = 1'b0;
    tick(243 + 66 + 50);
    for (int i = 0; i < 2; i++) chk("pre_rst_state", i, int'(st_o[i]), 3);
    rst_ni = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    step(); step();
    rst_ni = 1'b1;
    step(); step(); step();
    chk_reset_vals("post_rst");

    // Randomized traffic.
    for (int c = 0; c < 8000; c++) begin
      cen   = ($urandom_range(3) != 0);
      if ($urandom_range(1) == 0) vsync = ~vsync;
      start = ($urandom_range(39) == 0);
      abort = ($urandom_range(2999) == 0);
      pause = ($urandom_range(9) == 0);
      step();
    end
    cen = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
